bitcol_scheduler_16: RTL and testbench
======================================

Name: bitcol_scheduler_16

Overview:
- Control stage directly upstream of the 16-lane bit-column MAC (mac_unit_16_Vert).
- Accepts one 16-element signed weight vector and its 16-element activation vector per transaction, then walks the weight bit-columns LSB to MSB.
- For each column it emits the compacted activation-select list, the sum/skip mode, the column index and the MSB flag in the MAC's required timing, plus the activation sum.
- Also produces the accumulator clear and done strobes.

Parameters:
- DATA_WIDTH, 8, bit width of weights and activations; also the number of columns walked.
- VEC_LENGTH, 16, lanes per vector.
- MUX_SEL_WIDTH, $clog2(VEC_LENGTH)+1, width of each select code.
- SUM_ACT_WIDTH, $clog2(VEC_LENGTH)+DATA_WIDTH, width of the activation sum.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  weight/activation vector offered
- in_ready  out  1  block can accept a vector
- weight  in  DATA_WIDTH x VEC_LENGTH  signed weights
- act_in  in  DATA_WIDTH x VEC_LENGTH  signed activations
- act  out  DATA_WIDTH x VEC_LENGTH  latched activations, stable for the whole transaction
- sum_act  out  SUM_ACT_WIDTH  signed sum of the latched activations
- act_sel  out  MUX_SEL_WIDTH x VEC_LENGTH/2  compacted select codes, one cycle ahead of the controls
- column_idx  out  3  current column
- is_msb  out  1  current column is DATA_WIDTH-1
- is_skip_zero  out  1  1: selected lanes are the weight ones; 0: selected lanes are the zeros (diff mode)
- mac_en  out  1  MAC accumulate enable
- mac_clr  out  1  one-cycle accumulator clear, ORed into the MAC reset downstream
- done  out  1  one-cycle pulse; MAC result is final during this cycle

Behaviour:
- Reset values: in_ready=0 during reset, 1 in the first IDLE cycle; every act_sel slot=PAD_SEL (16); mac_en=mac_clr=done=0; column_idx=0; is_msb=0; is_skip_zero=1; act=0; sum_act=0.
- Reset mid-transaction: abort immediately to IDLE with the reset values above; no done pulse.
- Handshake:
  - Transfer happens when in_valid&&in_ready.
  - in_ready=1 only in IDLE.
  - On transfer, register weight, act_in→act and sum_act (full-width signed add of all 16 activations).
  - in_valid while busy is ignored.
- Column decision for column c:
  - pop = number of lanes i with weight[i][c]=1.
  - pop<=8: skip=1; select the lanes with bit=1.
  - pop>8: skip=0; select the lanes with bit=0 (at most 7).
  - Selected lane indices are packed ascending into slots 0..; remaining slots = PAD_SEL (16), which the downstream 17:1 mux resolves to zero.
- Timing: act_sel for a column is driven in cycle t. column_idx, is_msb, is_skip_zero and mac_en for the same column are registered and driven in cycle t+1, matching the MAC's internal select register.
- FSM:
  - IDLE → CLR on transfer.
  - CLR (1 cycle): mac_clr=1; act_sel = column 0 decision.
  - RUN: one cycle per column. Controls for column c are active (mac_en=1); act_sel already shows column c+1, or all PAD after the last column. Leave RUN after the cycle whose controls are for column DATA_WIDTH-1.
  - DONE (1 cycle): done=1, mac_en=0 → IDLE.
- Latency: transfer edge → done is 10 cycles (1 CLR + 8 RUN + 1 DONE); throughput is one vector per 11 cycles including IDLE.
- Boundary cases:
  - An all-zero column still issues mac_en (contributes 0).
  - pop=16 gives skip=0 with all slots PAD.
  - Column 7 asserts is_msb=1 with the same skip rule.
  - Outside RUN, mac_en=0 and the control registers hold their last values.

Optional Feature:
- ZERO_COL_SKIP_EN defined: columns with pop=0 are skipped. The select stage jumps to the next nonzero column via a priority search over a nonzero-column mask computed at transfer.
  - A vector with all columns zero goes CLR → DONE with no mac_en.
  - Latency is 2 + (nonzero column count) cycles.
- Undefined: all 8 columns are walked, with fixed latency.

Decomposition:
- Shared package bitsim_pkg: PAD_SEL constant (16), the FSM state enum (IDLE, CLR, RUN, DONE), and a column-decision struct (sel array, skip, idx, msb).
- One sub-module, bit_compactor_16to8: combinational. Input is a 16-bit lane mask plus the column bit vector. Outputs are popcount, the skip flag and 8 ascending packed select codes.

Test Plan:
- All weights 1, all activations 3 → column 0 has skip=0 with all slots PAD; columns 1–7 have skip=1; done at cycle 10; MAC result 48.
- All weights -1 (0xFF), all activations 1 → every column has skip=0 and all PAD; is_msb only on column 7; MAC result -16.
- weight[0]=5, others 0, act[0]=7 → columns 0 and 2 have act_sel slot0=0, rest PAD; MAC result 35. With ZERO_COL_SKIP_EN: exactly 2 mac_en cycles and done at cycle 4.
- Alternating weights 0x7F/0x00, random activations → per-column pop=8 keeps skip=1 with slots 0,2,...,14; MAC result matches the dot product.
- in_valid held high during RUN → in_ready=0 and the second vector is not latched until IDLE; a back-to-back transfer then yields a clean second result after mac_clr.
- Assert reset during RUN column 4 → next cycle all outputs are at reset values; no done pulse; the next transaction is correct.

Source files
------------

// File: rtl/bitsim_pkg.sv
// ---------------------------------------------------------------------------
// bitsim_pkg
// Shared definitions for the bit-column scheduler slice.
//   PAD_SEL        select code that the downstream 17:1 mux resolves to zero
//   state_t        scheduler FSM states (IDLE, CLR, RUN, DONE)
//   colDecision_t  everything decided about one weight bit-column: the packed
//                  select list, the sum/skip mode, the column index, MSB flag
//   lowestSet()    priority search returning {found, index} of the lowest set
//                  bit of a column mask
// No ports (package).
// ---------------------------------------------------------------------------
package bitsim_pkg;

    localparam int NUM_LANES = 16;
    localparam int NUM_SLOTS = 8;
    localparam int NUM_COLS  = 8;
    localparam int SEL_W     = 5;
    localparam int COL_W     = 3;

    localparam logic [SEL_W-1:0] PAD_SEL = 5'd16;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        RUN,
        DONE
    } state_t;

    typedef struct packed {
        logic [NUM_SLOTS-1:0][SEL_W-1:0] sel;
        logic                            skip;
        logic [COL_W-1:0]                idx;
        logic                            msb;
    } colDecision_t;

    localparam colDecision_t DEC_RESET = '{
        sel:  {NUM_SLOTS{PAD_SEL}},
        skip: 1'b1,
        idx:  '0,
        msb:  1'b0
    };

    // Lowest set bit wins; the MSB of the result says whether any bit was set.
    function automatic logic [COL_W:0] lowestSet(input logic [NUM_COLS-1:0] mask);
        logic [COL_W:0] result;
        result = '0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                result = {1'b1, COL_W'(i)};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_compactor_16to8.sv
// ---------------------------------------------------------------------------
// bit_compactor_16to8
// Combinational column compactor. Counts the set bits of one weight
// bit-column and picks the cheaper lane list for the MAC: the lanes whose bit
// is 1 when at most half are set (skip mode), otherwise the lanes whose bit is
// 0 (diff mode, the MAC subtracts them from the activation sum). Chosen lane
// indices are packed ascending into 8 slots, unused slots carry PAD_SEL.
// Ports:
//   laneMask_i  lanes taking part in the decision (all ones in normal use)
//   colBits_i   bit c of every lane's weight
//   popCount_o  number of enabled lanes whose bit is 1
//   skip_o      1: slots list the 1-lanes, 0: slots list the 0-lanes
//   sel_o       8 packed select codes, slot 0 in the low bits
// ---------------------------------------------------------------------------
module bit_compactor_16to8
    import bitsim_pkg::*;
(
    input  logic [NUM_LANES-1:0]            laneMask_i,
    input  logic [NUM_LANES-1:0]            colBits_i,
    output logic [SEL_W-1:0]                popCount_o,
    output logic                            skip_o,
    output logic [NUM_SLOTS-1:0][SEL_W-1:0] sel_o
);

    logic [NUM_LANES-1:0] ones;
    logic [NUM_LANES-1:0] chosen;
    logic [SEL_W-1:0]     slot;

    // Popcount, mode choice and ascending packing. With more than half the
    // lanes set at most 7 zero lanes remain, so the list always fits 8 slots;
    // the slot bound only keeps the indexing safe.
    always_comb begin
        ones       = colBits_i & laneMask_i;
        popCount_o = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            popCount_o = popCount_o + {{(SEL_W-1){1'b0}}, ones[i]};
        end
        skip_o = (popCount_o <= SEL_W'(NUM_SLOTS));
        chosen = skip_o ? ones : (~colBits_i & laneMask_i);
        sel_o  = {NUM_SLOTS{PAD_SEL}};
        slot   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (chosen[i] && (slot < SEL_W'(NUM_SLOTS))) begin
                sel_o[slot[$clog2(NUM_SLOTS)-1:0]] = SEL_W'(i);
                slot = slot + SEL_W'(1);
            end
        end
    end

endmodule

// File: rtl/bitcol_scheduler_16.sv
// ---------------------------------------------------------------------------
// bitcol_scheduler_16
// Control stage in front of the 16-lane bit-column MAC. Latches one signed
// weight vector and its activation vector, then walks the weight bit-columns
// LSB to MSB. act_sel for a column is presented one cycle before that
// column's controls, matching the select register inside the MAC.
// Optional build macro: ZERO_COL_SKIP_EN - columns with no set bit are never
// issued; the walk jumps to the next nonzero column.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   in_valid/ready  vector handshake, ready only in IDLE
//   weight, act_in  16 x 8-bit signed weights / activations
//   act, sum_act    latched activations and their signed sum
//   act_sel         8 compacted select codes (PAD_SEL = unused slot)
//   column_idx      column the MAC is processing this cycle
//   is_msb          that column is the sign column
//   is_skip_zero    1: selected lanes carry weight 1, 0: they carry weight 0
//   mac_en          MAC accumulate enable
//   mac_clr         one-cycle accumulator clear
//   done            one-cycle pulse, MAC result final in this cycle
// ---------------------------------------------------------------------------
module bitcol_scheduler_16
    import bitsim_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int VEC_LENGTH    = 16,
    parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH) + 1,
    parameter int SUM_ACT_WIDTH = $clog2(VEC_LENGTH) + DATA_WIDTH
)
(
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]        weight,
    input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]        act_in,
    output logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]        act,
    output logic [SUM_ACT_WIDTH-1:0]                     sum_act,
    output logic [VEC_LENGTH/2-1:0][MUX_SEL_WIDTH-1:0]   act_sel,
    output logic [2:0]                                   column_idx,
    output logic                                         is_msb,
    output logic                                         is_skip_zero,
    output logic                                         mac_en,
    output logic                                         mac_clr,
    output logic                                         done
);

    state_t                                  state_q;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]   weight_q;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]   act_q;
    logic [SUM_ACT_WIDTH-1:0]                sumAct_q;
    logic [SUM_ACT_WIDTH-1:0]                sumAct_d;
    logic [NUM_COLS-1:0]                     remMask_q;
    logic [NUM_COLS-1:0]                     remMask_d;
    colDecision_t                            dec_q;
    colDecision_t                            dec_d;
    logic                                    decValid_q;
    logic                                    decFound_d;
    logic [2:0]                              colIdx_q;
    logic                                    isMsb_q;
    logic                                    isSkip_q;
    logic                                    macEn_q;
    logic                                    macClr_q;
    logic                                    done_q;

    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]   srcWeight;
    logic [NUM_COLS-1:0]                     initMask;
    logic [NUM_COLS-1:0]                     curMask;
    logic [COL_W:0]                          pick;
    logic [NUM_LANES-1:0]                    colBits;
    logic [NUM_SLOTS-1:0][SEL_W-1:0]         cmpSel;
    logic                                    cmpSkip;
    logic [SEL_W-1:0]                        unusedPop;

    assign in_ready = (state_q == IDLE) && !reset;

    // Column selection. In IDLE the first decision is taken straight from the
    // incoming weights so that act_sel for the first column is already valid
    // in the CLR cycle; afterwards the latched weights and the mask of
    // columns still to issue drive the search.
    always_comb begin
        srcWeight = (state_q == IDLE) ? weight : weight_q;
`ifdef ZERO_COL_SKIP_EN
        initMask = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                initMask[c] = initMask[c] | weight[i][c];
            end
        end
`else
        initMask = '1;
`endif
        curMask = (state_q == IDLE) ? initMask : remMask_q;
        pick    = lowestSet(curMask);
        for (int i = 0; i < NUM_LANES; i++) begin
            colBits[i] = srcWeight[i][pick[COL_W-1:0]];
        end
    end

    bit_compactor_16to8 u_compactor (
        .laneMask_i (16'hFFFF),
        .colBits_i  (colBits),
        .popCount_o (unusedPop),
        .skip_o     (cmpSkip),
        .sel_o      (cmpSel)
    );

    // Next pending decision. When no column is left the select list goes to
    // all PAD so the MAC select register sees zeros after the last column.
    always_comb begin
        decFound_d  = pick[COL_W];
        dec_d.sel   = decFound_d ? cmpSel : {NUM_SLOTS{PAD_SEL}};
        dec_d.skip  = cmpSkip;
        dec_d.idx   = pick[COL_W-1:0];
        dec_d.msb   = (pick[COL_W-1:0] == COL_W'(NUM_COLS - 1));
        remMask_d   = curMask & ~(NUM_COLS'(1) << pick[COL_W-1:0]);
    end

    // Full-width signed sum of the incoming activations.
    always_comb begin
        sumAct_d = '0;
        for (int i = 0; i < VEC_LENGTH; i++) begin
            sumAct_d = sumAct_d
                     + {{(SUM_ACT_WIDTH-DATA_WIDTH){act_in[i][DATA_WIDTH-1]}}, act_in[i]};
        end
    end

    // Scheduler FSM. dec_q is the decision currently shown on act_sel; on the
    // next edge its mode/index/msb move into the control registers while the
    // following decision takes its place. CLR and RUN share that step: once no
    // valid decision is pending the walk is over and DONE follows.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            weight_q   <= '0;
            act_q      <= '0;
            sumAct_q   <= '0;
            remMask_q  <= '0;
            dec_q      <= DEC_RESET;
            decValid_q <= 1'b0;
            colIdx_q   <= '0;
            isMsb_q    <= 1'b0;
            isSkip_q   <= 1'b1;
            macEn_q    <= 1'b0;
            macClr_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        weight_q   <= weight;
                        act_q      <= act_in;
                        sumAct_q   <= sumAct_d;
                        dec_q      <= dec_d;
                        decValid_q <= decFound_d;
                        remMask_q  <= remMask_d;
                        macClr_q   <= 1'b1;
                        state_q    <= CLR;
                    end
                end
                CLR, RUN: begin
                    macClr_q <= 1'b0;
                    if (decValid_q) begin
                        colIdx_q   <= dec_q.idx;
                        isSkip_q   <= dec_q.skip;
                        isMsb_q    <= dec_q.msb;
                        macEn_q    <= 1'b1;
                        dec_q      <= dec_d;
                        decValid_q <= decFound_d;
                        remMask_q  <= remMask_d;
                        state_q    <= RUN;
                    end else begin
                        macEn_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign act          = act_q;
    assign sum_act      = sumAct_q;
    assign act_sel      = dec_q.sel;
    assign column_idx   = colIdx_q;
    assign is_msb       = isMsb_q;
    assign is_skip_zero = isSkip_q;
    assign mac_en       = macEn_q;
    assign mac_clr      = macClr_q;
    assign done         = done_q;

endmodule

// File: tb/tb_bitcol_scheduler_16.sv
// ---------------------------------------------------------------------------
// tb_bitcol_scheduler_16
// Directed bench for bitcol_scheduler_16. A table of weight/activation
// vectors with hand-computed dot products, activation sums, done latency and
// mac_en counts is applied in a loop; every cycle act_sel and the column
// controls are compared with a reference column decision, and a small MAC
// model consumes the DUT controls to rebuild the dot product. Hand-written
// sequences cover back-to-back transfers with in_valid held high and a reset
// in the middle of a walk. Honours ZERO_COL_SKIP_EN for the expectations.
// ---------------------------------------------------------------------------
module tb_bitcol_scheduler_16;

    localparam int DW  = 8;
    localparam int VL  = 16;
    localparam int SW  = 5;
    localparam int SAW = 12;
    localparam logic [39:0] ALL_PAD = {8{5'd16}};

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic [VL-1:0][DW-1:0]    weight;
    logic [VL-1:0][DW-1:0]    act_in;
    logic [VL-1:0][DW-1:0]    act;
    logic [SAW-1:0]           sum_act;
    logic [VL/2-1:0][SW-1:0]  act_sel;
    logic [2:0]               column_idx;
    logic                     is_msb;
    logic                     is_skip_zero;
    logic                     mac_en;
    logic                     mac_clr;
    logic                     done;

    typedef struct {
        logic [VL-1:0][DW-1:0] w;
        logic [VL-1:0][DW-1:0] a;
        int                    expResult;
        int                    expSum;
        int                    expDone;
        int                    expMacEn;
    } vec_t;

    vec_t tbl[6];
    int   total = 0;
    int   bad   = 0;
    int   cols[8];
    int   nCols;
    bit   aborted;

    always #5 clk = ~clk;

    bitcol_scheduler_16 dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .weight       (weight),
        .act_in       (act_in),
        .act          (act),
        .sum_act      (sum_act),
        .act_sel      (act_sel),
        .column_idx   (column_idx),
        .is_msb       (is_msb),
        .is_skip_zero (is_skip_zero),
        .mac_en       (mac_en),
        .mac_clr      (mac_clr),
        .done         (done)
    );

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] colOf(input logic [VL-1:0][DW-1:0] w, input int c);
        logic [15:0] r;
        for (int i = 0; i < VL; i++) r[i] = w[i][c];
        return r;
    endfunction

    // Reference column decision: ascending list of the minority lanes.
    function automatic logic [39:0] refSel(input logic [15:0] bits);
        logic [39:0] r;
        logic [15:0] want;
        int          k;
        want = ($countones(bits) <= 8) ? bits : ~bits;
        r    = ALL_PAD;
        k    = 0;
        for (int i = 0; i < VL; i++) begin
            if (want[i] && k < 8) begin
                r[k*5 +: 5] = 5'(i);
                k++;
            end
        end
        return r;
    endfunction

    task automatic buildCols(input int r);
        bit take;
        nCols = 0;
        for (int c = 0; c < 8; c++) begin
            take = 1'b1;
`ifdef ZERO_COL_SKIP_EN
            take = (colOf(tbl[r].w, c) != 16'h0);
`endif
            if (take) begin
                cols[nCols] = c;
                nCols++;
            end
        end
    endtask

    task automatic checkResetValues();
        checkOutput("rst_in_ready", longint'(in_ready), reset ? 0 : 1);
        checkOutput("rst_act_sel", longint'(act_sel), longint'(ALL_PAD));
        checkOutput("rst_mac_en", longint'(mac_en), 0);
        checkOutput("rst_mac_clr", longint'(mac_clr), 0);
        checkOutput("rst_done", longint'(done), 0);
        checkOutput("rst_column_idx", longint'(column_idx), 0);
        checkOutput("rst_is_msb", longint'(is_msb), 0);
        checkOutput("rst_is_skip_zero", longint'(is_skip_zero), 1);
        checkOutput("rst_act_lo", longint'(act[7:0]), 0);
        checkOutput("rst_act_hi", longint'(act[15:8]), 0);
        checkOutput("rst_sum_act", longint'(sum_act), 0);
    endtask

    // Offers a vector and returns #1 after the transfer edge.
    task automatic applyStimulus(input int r);
        int waitCnt;
        in_valid = 1'b1;
        weight   = tbl[r].w;
        act_in   = tbl[r].a;
        waitCnt  = 0;
        while (!in_ready && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("handshake_ready", longint'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Follows one transaction cycle by cycle from the transfer edge.
    task automatic runAndCheck(input int r, input int abortCol, output bit ab);
        int          n;
        int          acc;
        int          macCnt;
        int          doneCyc;
        int          selSum;
        int          contrib;
        int          lane;
        logic [39:0] prevSel;
        logic [39:0] expSel;
        bit          expEn;
        buildCols(r);
        ab      = 1'b0;
        n       = 1;
        acc     = 0;
        macCnt  = 0;
        doneCyc = 0;
        prevSel = ALL_PAD;
        checkOutput("sum_act", longint'(int'($signed(sum_act))), tbl[r].expSum);
        while (doneCyc == 0 && n <= 24 && !ab) begin
            checkOutput("in_ready_busy", longint'(in_ready), 0);
            checkOutput("act_lo", longint'(act[7:0]), longint'(tbl[r].a[7:0]));
            checkOutput("act_hi", longint'(act[15:8]), longint'(tbl[r].a[15:8]));
            checkOutput("mac_clr", longint'(mac_clr), (n == 1) ? 1 : 0);
            expSel = (n - 1 < nCols) ? refSel(colOf(tbl[r].w, cols[n-1])) : ALL_PAD;
            checkOutput("act_sel", longint'(act_sel), longint'(expSel));
            expEn = (n >= 2) && (n <= nCols + 1);
            checkOutput("mac_en", longint'(mac_en), longint'(expEn));
            if (mac_en) begin
                macCnt++;
                if (expEn) begin
                    checkOutput("column_idx", longint'(column_idx), cols[n-2]);
                    checkOutput("is_skip_zero", longint'(is_skip_zero),
                                longint'($countones(colOf(tbl[r].w, cols[n-2])) <= 8));
                    checkOutput("is_msb", longint'(is_msb), (cols[n-2] == 7) ? 1 : 0);
                end
                selSum = 0;
                for (int s = 0; s < 8; s++) begin
                    lane = int'(prevSel[s*5 +: 5]);
                    if (lane != 16) selSum += int'($signed(tbl[r].a[lane]));
                end
                contrib = is_skip_zero ? selSum : (tbl[r].expSum - selSum);
                if (is_msb) acc -= (contrib <<< column_idx);
                else        acc += (contrib <<< column_idx);
            end
            if (mac_clr) acc = 0;
            if (done) begin
                doneCyc = n;
            end else if (abortCol >= 0 && mac_en && int'(column_idx) == abortCol) begin
                ab = 1'b1;
            end else begin
                prevSel = act_sel;
                @(posedge clk);
                #1;
                n++;
            end
        end
        if (!ab) begin
            checkOutput("done_latency", doneCyc, tbl[r].expDone);
            checkOutput("mac_en_count", macCnt, tbl[r].expMacEn);
            checkOutput("mac_result", acc, tbl[r].expResult);
            @(posedge clk);
            #1;
            checkOutput("done_pulse_width", longint'(done), 0);
            checkOutput("idle_in_ready", longint'(in_ready), 1);
            checkOutput("idle_mac_en", longint'(mac_en), 0);
            checkOutput("idle_act_sel", longint'(act_sel), longint'(ALL_PAD));
            if (nCols > 0) begin
                checkOutput("hold_column_idx", longint'(column_idx), cols[nCols-1]);
                checkOutput("hold_is_msb", longint'(is_msb), (cols[nCols-1] == 7) ? 1 : 0);
            end
        end
    endtask

    initial begin
        // Vector table with hand-computed results.
        tbl[0].w = {16{8'h01}}; tbl[0].a = {16{8'h03}};
        tbl[0].expResult = 48;    tbl[0].expSum = 48;
        tbl[1].w = {16{8'hFF}}; tbl[1].a = {16{8'h01}};
        tbl[1].expResult = -16;   tbl[1].expSum = 16;
        tbl[2].w = '0;          tbl[2].a = '0;
        tbl[2].w[0] = 8'h05;    tbl[2].a[0] = 8'h07;
        tbl[2].expResult = 35;    tbl[2].expSum = 7;
        for (int i = 0; i < VL; i++) begin
            tbl[3].w[i] = (i % 2 == 0) ? 8'h7F : 8'h00;
            tbl[3].a[i] = 8'(i - 8);
        end
        tbl[3].expResult = -1016; tbl[3].expSum = -8;
        tbl[4].w = {16{8'h80}}; tbl[4].a = {16{8'h01}};
        tbl[4].expResult = -2048; tbl[4].expSum = 16;
        tbl[5].w = '0;
        for (int i = 0; i < VL; i++) tbl[5].a[i] = 8'(i);
        tbl[5].expResult = 0;     tbl[5].expSum = 120;
`ifdef ZERO_COL_SKIP_EN
        tbl[0].expDone = 3;  tbl[0].expMacEn = 1;
        tbl[1].expDone = 10; tbl[1].expMacEn = 8;
        tbl[2].expDone = 4;  tbl[2].expMacEn = 2;
        tbl[3].expDone = 9;  tbl[3].expMacEn = 7;
        tbl[4].expDone = 3;  tbl[4].expMacEn = 1;
        tbl[5].expDone = 2;  tbl[5].expMacEn = 0;
`else
        for (int r = 0; r < 6; r++) begin
            tbl[r].expDone  = 10;
            tbl[r].expMacEn = 8;
        end
`endif

        reset    = 1'b1;
        in_valid = 1'b0;
        weight   = '0;
        act_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues();
        reset = 1'b0;
        #1;
        checkOutput("in_ready_after_reset", longint'(in_ready), 1);

        $display("[TB] table vectors");
        for (int r = 0; r < 6; r++) begin
            applyStimulus(r);
            runAndCheck(r, -1, aborted);
        end

        $display("[TB] back-to-back with in_valid held high");
        applyStimulus(0);
        in_valid = 1'b1;
        weight   = tbl[2].w;
        act_in   = tbl[2].a;
        runAndCheck(0, -1, aborted);
        applyStimulus(2);
        runAndCheck(2, -1, aborted);

        $display("[TB] reset during column 4");
        applyStimulus(1);
        runAndCheck(1, 4, aborted);
        checkOutput("abort_point_reached", longint'(aborted), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkResetValues();
        reset = 1'b0;
        #1;
        checkOutput("in_ready_after_abort", longint'(in_ready), 1);
        checkOutput("no_done_after_abort", longint'(done), 0);
        applyStimulus(3);
        runAndCheck(3, -1, aborted);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
